and_unit_arbiter: RTL and testbench
===================================

Name: and_unit_arbiter

Overview:
- Round-robin arbiter that shares one registered 1-bit AND evaluation unit (C = A & B) between N requesters.
- Each requester presents an operand pair and holds a request. The arbiter grants one requester at a time and captures its operands.
- It returns the result tagged with the requester index, and keeps a wrapping operation count.
- Sits between the assignment's requester blocks and the shared logic resource; it is the only driver of that resource.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must satisfy 2**ID_W >= N_REQ.
- CNT_W, 8, width of completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N_REQ  per-requester request, level; held until own gnt bit seen.
- a_in  input  N_REQ  operand A, one bit per requester; valid while that req is high.
- b_in  input  N_REQ  operand B, one bit per requester; valid while that req is high.
- req_mask  input  N_REQ  1 = requester enabled; masked requests are ignored.
- gnt  output  N_REQ  one-hot grant, one-cycle pulse, registered.
- res_valid  output  1  result strobe, one-cycle pulse.
- res_data  output  1  A & B of the granted requester.
- res_id  output  ID_W  index of the requester owning res_data.
- busy  output  1  high while state is EXEC.
- op_count  output  CNT_W  completed operations, wraps modulo 2**CNT_W.

Behaviour:
- Interface rule, decided: one clock, clk; reset rst is synchronous and active-high. All state changes on the rising edge of clk only.
- Reset values: state=IDLE, gnt=0, res_valid=0, res_data=0, res_id=0, busy=0, op_count=0, rr_ptr=0, captured operands=0.
- Effective request vector: eff = req & req_mask.
- FSM has two states.
- IDLE, eff != 0 in cycle t:
  - Select winner w: first set bit of eff at or after rr_ptr, searching upward and wrapping from N_REQ-1 to 0.
  - At the edge ending cycle t: gnt <= onehot(w), capture a_in[w] and b_in[w], id <= w, state <= EXEC.
- IDLE, eff == 0: stay in IDLE; gnt=0.
- EXEC (cycle t+1): gnt high, busy high.
  - At the edge ending cycle t+1: res_data <= a_cap & b_cap, res_id <= id, res_valid <= 1, gnt <= 0, rr_ptr <= (w+1) mod N_REQ, op_count <= op_count+1, state <= IDLE.
- Latency: request sampled in cycle t gives gnt in cycle t+1 and res_valid/res_data in cycle t+2.
- Throughput: one operation per 2 cycles. The IDLE cycle that carries res_valid may arbitrate a new request, so res_valid of operation k coincides with gnt arbitration for operation k+1. Result and grant pulses never overlap for the same operation.
- Requester protocol:
  - Drop req on the edge after seeing its gnt bit.
  - A req still high in the next IDLE cycle counts as a new request.
  - Operands are sampled only in the arbitration cycle; changes during EXEC are ignored.
- Outputs res_data and res_id hold their last value when res_valid=0.
- Mask/req changes during EXEC do not affect the operation in flight.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N_REQ-1,0...
  - No requester waits more than N_REQ-1 grants.
- Only enabled requesters are granted. A masked-off requester never gets gnt, even if its req is high.
- rr_ptr updates only on completion, not on arbitration.
- op_count rolls from 2**CNT_W-1 to 0 without a flag.
- rst asserted in any state, including EXEC: all outputs take reset values next edge. The in-flight operation is discarded: no res_valid, op_count not incremented. rst has priority over all events.
- With N_REQ not a power of two, rr_ptr wraps from N_REQ-1 to 0. Indices >= N_REQ are never produced.

Test Plan:
- Reset then single request: req=0001, a_in=0001, b_in=0001, mask=1111 -> gnt=0001 at t+1; res_valid=1, res_data=1, res_id=0 at t+2; op_count=1.
- Operand truth table on requester 2: (A,B)=(0,0),(0,1),(1,0),(1,1) -> res_data=0,0,0,1 with res_id=2; op_count=4.
- All four requesting continuously -> gnt sequence 0001,0010,0100,1000,0001 at cycles t+1,t+3,t+5,t+7,t+9; res_id 0,1,2,3,0.
- Mask test: req=1111, mask=1010 -> only gnt 0010 and 1000 alternate; requesters 0 and 2 never granted.
- Reset during EXEC: assert rst in the gnt cycle -> next cycle gnt=0, res_valid=0, op_count=0, rr_ptr=0; the next req=1000 is granted normally.
- Counter wrap with CNT_W=8: 256 completed operations -> op_count returns to 0; operation 257 gives op_count=1.

Source files
------------

// File: rtl/and_unit_arbiter_if.sv
// Requester-side bundle for the shared AND-unit arbiter: per-requester request/operands in,
// one-hot grant and tagged result out.
interface and_unit_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] a_in;
  logic [N_REQ-1:0] b_in;
  logic [N_REQ-1:0] req_mask;
  logic [N_REQ-1:0] gnt;
  logic             res_valid;
  logic             res_data;
  logic [ID_W-1:0]  res_id;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport master (
    output req, a_in, b_in, req_mask,
    input  gnt, res_valid, res_data, res_id, busy, op_count
  );

  modport slave (
    input  req, a_in, b_in, req_mask,
    output gnt, res_valid, res_data, res_id, busy, op_count
  );
endinterface

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one registered 1-bit AND unit between N_REQ requesters.
// Two-state FSM: IDLE arbitrates and captures operands, EXEC evaluates and returns the result.
module and_unit_arbiter_lane (
  input  logic req,
  input  logic mask,
  input  logic a,
  input  logic b,
  input  logic win,
  output logic eff,
  output logic a_pick,
  output logic b_pick
);
  assign eff    = req & mask;
  assign a_pick = a & win;
  assign b_pick = b & win;
endmodule

module and_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  and_unit_arbiter_if.slave bus
);
  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] eff, win_oh, a_pick, b_pick;
  logic [ID_W-1:0]  win_idx, rr_ptr, cur_id;
  logic             launch, complete;
  logic             a_cap, b_cap;
  logic [N_REQ-1:0] gnt_q;
  logic             res_valid_q, res_data_q;
  logic [ID_W-1:0]  res_id_q;
  logic [CNT_W-1:0] op_count_q;

  // First enabled requester at or above ptr, otherwise the lowest one below it (wrap-around).
  function automatic logic [ID_W-1:0] pick(input logic [N_REQ-1:0] e, input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] w_hi, w_lo;
    logic            hit_hi;
    w_hi   = '0;
    w_lo   = '0;
    hit_hi = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (e[i]) begin
        w_lo = ID_W'(i);
        if (i >= int'(ptr)) begin
          w_hi   = ID_W'(i);
          hit_hi = 1'b1;
        end
      end
    end
    return hit_hi ? w_hi : w_lo;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    and_unit_arbiter_lane u_lane (
      .req    (bus.req[g]),
      .mask   (bus.req_mask[g]),
      .a      (bus.a_in[g]),
      .b      (bus.b_in[g]),
      .win    (win_oh[g]),
      .eff    (eff[g]),
      .a_pick (a_pick[g]),
      .b_pick (b_pick[g])
    );
  end

  always_comb begin
    win_idx = pick(eff, rr_ptr);
    win_oh  = '0;
    if (|eff) win_oh[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (|eff) begin
          launch    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        complete  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset discards an operation in flight: the EXEC completion never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= '0;
      a_cap       <= 1'b0;
      b_cap       <= 1'b0;
      cur_id      <= '0;
      rr_ptr      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 1'b0;
      res_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      gnt_q       <= launch ? win_oh : '0;
      res_valid_q <= complete;
      if (launch) begin
        a_cap  <= |a_pick;
        b_cap  <= |b_pick;
        cur_id <= win_idx;
      end
      if (complete) begin
        res_data_q <= a_cap & b_cap;
        res_id_q   <= cur_id;
        rr_ptr     <= next_ptr(cur_id);
        op_count_q <= op_count_q + 1'b1;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state == EXEC);
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_and_unit_arbiter.sv
// Scoreboard bench for and_unit_arbiter: stimulus pushes expected grants/results,
// a forked monitor pops and compares them whenever the DUT shows a grant or result.
module tb_and_unit_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 8;

  typedef struct packed {
    logic           data;
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  and_unit_arbiter_if #(.N_REQ(N), .ID_W(IDW), .CNT_W(CW)) bus ();

  and_unit_arbiter #(.N_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t          res_q[$];
  logic [N-1:0]  gnt_q[$];
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        if (gnt_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_gnt: got unexpected %b expected none", bus.gnt);
        end else begin
          check("sb_gnt", 32'(bus.gnt), 32'(gnt_q.pop_front()));
        end
      end
      if (bus.res_valid) begin
        if (res_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_res: got unexpected result id %0d expected none", bus.res_id);
        end else begin
          res_t e;
          e = res_q.pop_front();
          check("sb_res_data", 32'(bus.res_data), 32'(e.data));
          check("sb_res_id",   32'(bus.res_id),   32'(e.id));
          check("sb_op_count", 32'(bus.op_count), 32'(e.cnt));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    tick();
    tick();
    rst     = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic expect_op(input int idx, input logic d);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    exp_cnt = exp_cnt + 1'b1;
    gnt_q.push_back(oh);
    res_q.push_back('{data: d, id: IDW'(idx), cnt: exp_cnt});
  endtask

  // Single request; returns positioned in the result cycle with req already dropped.
  task automatic do_op(input int idx, input logic a, input logic b);
    logic ok;
    bus.req       = '0;
    bus.req[idx]  = 1'b1;
    bus.a_in[idx] = a;
    bus.b_in[idx] = b;
    expect_op(idx, a & b);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (bus.gnt[idx]) ok = 1'b1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL gnt_timeout: got no grant for requester %0d expected one within 20 cycles", idx);
    end
    tick();
    bus.req = '0;
  endtask

  initial begin
    logic [N-1:0] seq_all[5];
    logic [N-1:0] seq_msk[4];
    seq_all = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq_msk = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.req_mask = '1;
    exp_cnt = '0;
    fork
      monitor();
    join_none

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_res_data", 32'(bus.res_data), 0);
    check("rst_res_id", 32'(bus.res_id), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_op_count", 32'(bus.op_count), 0);
    rst = 1'b0;

    // Single request latency
    bus.req = 4'b0001; bus.a_in = 4'b0001; bus.b_in = 4'b0001;
    expect_op(0, 1'b1);
    tick();
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    check("t1_busy", 32'(bus.busy), 1);
    check("t1_res_valid_early", 32'(bus.res_valid), 0);
    tick();
    bus.req = '0;
    check("t1_res_valid", 32'(bus.res_valid), 1);
    check("t1_res_data", 32'(bus.res_data), 1);
    check("t1_res_id", 32'(bus.res_id), 0);
    check("t1_op_count", 32'(bus.op_count), 1);
    check("t1_gnt_off", 32'(bus.gnt), 0);
    tick();
    check("t1_res_valid_pulse", 32'(bus.res_valid), 0);
    check("t1_res_data_hold", 32'(bus.res_data), 1);

    // Operand truth table on requester 2
    do_reset();
    do_op(2, 1'b0, 1'b0);
    do_op(2, 1'b0, 1'b1);
    do_op(2, 1'b1, 1'b0);
    do_op(2, 1'b1, 1'b1);
    check("tt_op_count", 32'(bus.op_count), 4);
    tick();

    // All requesting continuously: rotation 0,1,2,3,0
    do_reset();
    bus.a_in = 4'b1010; bus.b_in = 4'b1110;
    expect_op(0, 1'b0); expect_op(1, 1'b1); expect_op(2, 1'b0);
    expect_op(3, 1'b1); expect_op(0, 1'b0);
    bus.req = 4'b1111;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("rr_gnt_timing", 32'(bus.gnt), (c % 2 == 1) ? 32'(seq_all[c/2]) : 0);
    end
    bus.req = '0;
    repeat (3) tick();

    // Mask 1010: only requesters 1 and 3 alternate
    do_reset();
    bus.req_mask = 4'b1010; bus.a_in = 4'b1111; bus.b_in = 4'b0010;
    expect_op(1, 1'b1); expect_op(3, 1'b0); expect_op(1, 1'b1); expect_op(3, 1'b0);
    bus.req = 4'b1111;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check("mask_gnt_timing", 32'(bus.gnt), (c % 2 == 1) ? 32'(seq_msk[c/2]) : 0);
    end
    bus.req = '0;
    repeat (3) tick();
    bus.req_mask = 4'b1111;

    // Reset during EXEC discards the operation and clears rr_ptr
    do_reset();
    do_op(1, 1'b1, 1'b1);
    tick();
    bus.req = 4'b0100; bus.a_in = 4'b1111; bus.b_in = 4'b1111;
    gnt_q.push_back(4'b0100);
    tick();
    check("rx_gnt", 32'(bus.gnt), 32'h4);
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
    exp_cnt = '0;
    check("rx_gnt_clr", 32'(bus.gnt), 0);
    check("rx_res_valid", 32'(bus.res_valid), 0);
    check("rx_op_count", 32'(bus.op_count), 0);
    check("rx_busy", 32'(bus.busy), 0);
    bus.req = 4'b1010;
    expect_op(1, 1'b1);
    tick();
    check("rx_rr_ptr_zero", 32'(bus.gnt), 32'h2);
    tick();
    bus.req = '0;
    do_op(3, 1'b1, 1'b0);
    check("rx_op_count_after", 32'(bus.op_count), 2);
    tick();

    // Counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) do_op(0, i[0], i[1]);
    check("wrap_op_count_256", 32'(bus.op_count), 0);
    do_op(0, 1'b1, 1'b1);
    check("wrap_op_count_257", 32'(bus.op_count), 1);

    repeat (3) tick();
    check("sb_gnt_drained", gnt_q.size(), 0);
    check("sb_res_drained", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
